// File: rtl/des_sched_pkg.sv
// des_sched_pkg: slot state encoding and data widths shared by the block scheduler.
package des_sched_pkg;
    localparam int SEED_W = 64;
    localparam int CNT_W = 64;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_CLEAR = 3'd4
    } slot_state_e;
endpackage

// File: rtl/des_sched_slot.sv
// des_sched_slot: per-block job FSM holding the seed, id and captured counter for one des_block.
module des_sched_slot
    import des_sched_pkg::*;
#(
    parameter int ID_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_i,
    input  logic [SEED_W-1:0] seed_i,
    input  logic [ID_W-1:0]   id_i,
    input  logic              done_i,
    input  logic [CNT_W-1:0]  counter_i,
    input  logic              grant_i,
    output slot_state_e       state_o,
    output logic [SEED_W-1:0] seed_o,
    output logic [ID_W-1:0]   id_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              start_o,
    output logic              restart_o
);
    slot_state_e       state_q;
    logic [SEED_W-1:0] seed_q;
    logic [ID_W-1:0]   id_q;
    logic [CNT_W-1:0]  count_q;

    // Reset parks the slot in CLEAR so the block gets a restart pulse right after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLEAR;
            seed_q  <= '0;
            id_q    <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (dispatch_i) begin
                    state_q <= S_START;
                    seed_q  <= seed_i;
                    id_q    <= id_i;
                end
                S_START: state_q <= S_RUN;
                S_RUN: if (done_i) begin
                    state_q <= S_DONE;
                    count_q <= counter_i;
                end
                S_DONE: if (grant_i) state_q <= S_CLEAR;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state_o   = state_q;
    assign seed_o    = seed_q;
    assign id_o      = id_q;
    assign count_o   = count_q;
    assign start_o   = state_q == S_START;
    assign restart_o = state_q == S_CLEAR && !rst;
endmodule

// File: rtl/des_block_scheduler.sv
// des_block_scheduler: dispatches seed jobs to idle des_blocks and returns {id, count} results round-robin.
// Optional DES_SCHED_ACCUM_EN adds a running total of delivered counts (tot_count / tot_clear).
module des_block_scheduler
    import des_sched_pkg::*;
#(
    parameter int N_BLOCKS = 4,
    parameter int ID_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [ID_W-1:0]            job_id,
    input  logic [SEED_W-1:0]          job_seed,
    output logic [SEED_W*N_BLOCKS-1:0] blk_seed,
    output logic [N_BLOCKS-1:0]        blk_start,
    output logic [N_BLOCKS-1:0]        blk_restart,
    input  logic [N_BLOCKS-1:0]        blk_done,
    input  logic [CNT_W*N_BLOCKS-1:0]  blk_counter,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ID_W-1:0]            res_id,
    output logic [CNT_W-1:0]           res_count,
`ifdef DES_SCHED_ACCUM_EN
    input  logic                       tot_clear,
    output logic [CNT_W-1:0]           tot_count,
`endif
    output logic                       busy
);
    localparam int IW = N_BLOCKS > 1 ? $clog2(N_BLOCKS) : 1;

    slot_state_e         st       [N_BLOCKS];
    logic [ID_W-1:0]     slot_id  [N_BLOCKS];
    logic [CNT_W-1:0]    slot_cnt [N_BLOCKS];
    logic [N_BLOCKS-1:0] dispatch, grant;
    logic                idle_any, active_any, done_any, load;
    logic [IW-1:0]       ptr_q, gidx, ridx;
    logic                res_valid_q;
    logic [ID_W-1:0]     res_id_q;
    logic [CNT_W-1:0]    res_count_q;

    for (genvar i = 0; i < N_BLOCKS; i++) begin : g_slot
        des_sched_slot #(.ID_W(ID_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .dispatch_i(dispatch[i]),
            .seed_i    (job_seed),
            .id_i      (job_id),
            .done_i    (blk_done[i]),
            .counter_i (blk_counter[CNT_W*i +: CNT_W]),
            .grant_i   (grant[i]),
            .state_o   (st[i]),
            .seed_o    (blk_seed[SEED_W*i +: SEED_W]),
            .id_o      (slot_id[i]),
            .count_o   (slot_cnt[i]),
            .start_o   (blk_start[i]),
            .restart_o (blk_restart[i])
        );
    end

    always_comb begin
        idle_any = 1'b0;
        active_any = 1'b0;
        dispatch = '0;
        for (int i = 0; i < N_BLOCKS; i++) begin
            dispatch[i] = job_valid && !idle_any && st[i] == S_IDLE;
            idle_any = idle_any || st[i] == S_IDLE;
            active_any = active_any || st[i] != S_IDLE;
        end
    end

    // First DONE slot at or after the round-robin pointer wins the result register.
    always_comb begin
        done_any = 1'b0;
        gidx = '0;
        ridx = '0;
        for (int k = 0; k < N_BLOCKS; k++) begin
            ridx = IW'((int'(ptr_q) + k) % N_BLOCKS);
            if (!done_any && st[ridx] == S_DONE) begin
                done_any = 1'b1;
                gidx = ridx;
            end
        end
    end

    assign load  = done_any && (!res_valid_q || res_ready);
    assign grant = load ? N_BLOCKS'(1) << gidx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_count_q <= '0;
            ptr_q       <= '0;
        end else begin
            res_valid_q <= load || (res_valid_q && !res_ready);
            if (load) begin
                res_id_q    <= slot_id[gidx];
                res_count_q <= slot_cnt[gidx];
                ptr_q       <= gidx == IW'(N_BLOCKS - 1) ? '0 : gidx + 1'b1;
            end
        end
    end

`ifdef DES_SCHED_ACCUM_EN
    logic [CNT_W-1:0] tot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tot_q <= '0;
        else if (tot_clear) tot_q <= '0;
        else if (res_valid_q && res_ready) tot_q <= tot_q + res_count_q;
    end

    assign tot_count = tot_q;
`endif

    assign job_ready = idle_any;
    assign busy      = (active_any || res_valid_q) && !rst;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_count = res_count_q;
endmodule

// File: tb/tb_des_block_scheduler.sv
// tb_des_block_scheduler: directed scoreboard bench for des_block_scheduler (N_BLOCKS=4, ID_W=8).
module tb_des_block_scheduler;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic [7:0]   job_id = '0;
    logic [63:0]  job_seed = '0;
    logic [255:0] blk_seed;
    logic [255:0] blk_counter = '0;
    logic [3:0]   blk_start, blk_restart;
    logic [3:0]   blk_done = '0;
    logic         res_valid, busy, job_ready;
    logic [7:0]   res_id;
    logic [63:0]  res_count;
`ifdef DES_SCHED_ACCUM_EN
    logic         tot_clear = 1'b0;
    logic [63:0]  tot_count;
`endif
    int           checks = 0;
    int           failures = 0;
    logic [71:0]  sb [$];
    logic [71:0]  mon_e;

    always #5 clk = ~clk;

    des_block_scheduler #(.N_BLOCKS(4), .ID_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_id     (job_id),
        .job_seed   (job_seed),
        .blk_seed   (blk_seed),
        .blk_start  (blk_start),
        .blk_restart(blk_restart),
        .blk_done   (blk_done),
        .blk_counter(blk_counter),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_count  (res_count),
`ifdef DES_SCHED_ACCUM_EN
        .tot_clear  (tot_clear),
        .tot_count  (tot_count),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Handshakes complete on the next rising edge; compare against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("result_expected", 64'(res_id), 64'hFFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("res_id", 64'(res_id), 64'(mon_e[71:64]));
                chk("res_count", res_count, mon_e[63:0]);
            end
        end
    end

    initial begin
        repeat (3) tick;
        chk("reset_restart", 64'(blk_restart), 64'd0);
        chk("reset_job_ready", 64'(job_ready), 64'd0);
        chk("reset_res_valid", 64'(res_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_seed_zero", 64'(|blk_seed), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_restart", 64'(blk_restart), 64'hF);
        chk("post_reset_job_ready", 64'(job_ready), 64'd0);
        tick;
        chk("restart_one_cycle", 64'(blk_restart), 64'd0);
        chk("idle_job_ready", 64'(job_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 4; i++) begin
            job_valid = 1'b1;
            job_id = 8'(i + 1);
            job_seed = 64'(i + 1);
            tick;
            chk("start_slot", 64'(blk_start), 64'(1) << i);
            chk("seed_slot", blk_seed[64*i +: 64], 64'(i + 1));
        end
        job_id = 8'd5;
        job_seed = 64'd5;
        chk("full_job_ready", 64'(job_ready), 64'd0);
        repeat (2) begin
            tick;
            chk("full_job_ready_hold", 64'(job_ready), 64'd0);
            chk("full_no_start", 64'(blk_start), 64'd0);
        end

        blk_counter[128 +: 64] = 64'd17;
        blk_done = 4'b0100;
        sb.push_back({8'd3, 64'd17});
        res_ready = 1'b1;
        tick;
        blk_done = 4'b0000;
        chk("done_no_result_yet", 64'(res_valid), 64'd0);
        tick;
        chk("slot2_res_valid", 64'(res_valid), 64'd1);
        chk("slot2_restart", 64'(blk_restart), 64'b0100);
        chk("clear_not_dispatchable", 64'(job_ready), 64'd0);
        tick;
        chk("slot2_restart_end", 64'(blk_restart), 64'd0);
        chk("slot2_idle_ready", 64'(job_ready), 64'd1);
        chk("slot2_res_drained", 64'(res_valid), 64'd0);
        tick;
        job_valid = 1'b0;
        chk("job5_start_slot2", 64'(blk_start), 64'b0100);
        chk("job5_seed_slot2", blk_seed[128 +: 64], 64'd5);

        blk_counter[0 +: 64] = 64'd5;
        blk_done = 4'b0001;
        sb.push_back({8'd1, 64'd5});
        tick;
        blk_done = 4'b0000;
        tick;
        chk("slot0_res_valid", 64'(res_valid), 64'd1);
        chk("slot0_restart", 64'(blk_restart), 64'b0001);
        tick;
        chk("slot0_restart_end", 64'(blk_restart), 64'd0);

        blk_counter[0 +: 64] = 64'd999;
        blk_done = 4'b0001;
        tick;
        blk_done = 4'b0000;
        tick;
        chk("done_ignored_idle", 64'(res_valid), 64'd0);
        chk("busy_running", 64'(busy), 64'd1);

        job_valid = 1'b1;
        job_id = 8'd6;
        job_seed = 64'd6;
        tick;
        job_valid = 1'b0;
        chk("job6_start_slot0", 64'(blk_start), 64'b0001);
        tick;

        for (int i = 0; i < 4; i++) blk_counter[64*i +: 64] = 64'(100 + i);
        blk_done = 4'b1111;
        sb.push_back({8'd2, 64'd101});
        sb.push_back({8'd5, 64'd102});
        sb.push_back({8'd4, 64'd103});
        sb.push_back({8'd6, 64'd100});
        tick;
        blk_done = 4'b0000;
        repeat (4) begin
            tick;
            chk("burst_res_valid", 64'(res_valid), 64'd1);
        end
        tick;
        chk("burst_end", 64'(res_valid), 64'd0);
        tick;
        chk("all_idle_busy", 64'(busy), 64'd0);

        res_ready = 1'b0;
        job_valid = 1'b1;
        job_id = 8'd7;
        job_seed = 64'd7;
        tick;
        job_id = 8'd8;
        job_seed = 64'd8;
        tick;
        job_valid = 1'b0;
        tick;
        blk_counter[0 +: 64] = 64'd200;
        blk_counter[64 +: 64] = 64'd201;
        blk_done = 4'b0011;
        sb.push_back({8'd8, 64'd201});
        sb.push_back({8'd7, 64'd200});
        tick;
        blk_done = 4'b0000;
        tick;
        chk("bp_res_valid", 64'(res_valid), 64'd1);
        chk("bp_res_id", 64'(res_id), 64'd8);
        chk("bp_restart_slot1", 64'(blk_restart), 64'b0010);
        for (int c = 0; c < 20; c++) begin
            tick;
            chk("bp_hold_valid", 64'(res_valid), 64'd1);
            chk("bp_hold_id", 64'(res_id), 64'd8);
            chk("bp_hold_count", res_count, 64'd201);
            chk("bp_no_restart", 64'(blk_restart), 64'd0);
        end
        res_ready = 1'b1;
        tick;
        chk("bp_second_valid", 64'(res_valid), 64'd1);
        chk("bp_second_id", 64'(res_id), 64'd7);
        chk("bp_restart_slot0", 64'(blk_restart), 64'b0001);
        tick;
        chk("bp_drained", 64'(res_valid), 64'd0);
        repeat (2) tick;
        chk("final_busy", 64'(busy), 64'd0);

`ifdef DES_SCHED_ACCUM_EN
        tot_clear = 1'b1;
        tick;
        tot_clear = 1'b0;
        chk("tot_cleared", tot_count, 64'd0);
        job_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            job_id = 8'(9 + i);
            job_seed = 64'(9 + i);
            tick;
        end
        job_valid = 1'b0;
        tick;
        blk_counter[0 +: 64] = 64'd10;
        blk_counter[64 +: 64] = 64'd20;
        blk_counter[128 +: 64] = '1;
        blk_done = 4'b0111;
        sb.push_back({8'd10, 64'd20});
        sb.push_back({8'd11, 64'hFFFF_FFFF_FFFF_FFFF});
        sb.push_back({8'd9, 64'd10});
        tick;
        blk_done = 4'b0000;
        repeat (4) tick;
        chk("tot_wrap", tot_count, 64'd29);
        blk_counter[0 +: 64] = 64'd50;
        job_valid = 1'b1;
        job_id = 8'd12;
        job_seed = 64'd12;
        tick;
        job_valid = 1'b0;
        tick;
        blk_done = 4'b0001;
        sb.push_back({8'd12, 64'd50});
        tick;
        blk_done = 4'b0000;
        tick;
        chk("tot_clear_res_valid", 64'(res_valid), 64'd1);
        tot_clear = 1'b1;
        tick;
        tot_clear = 1'b0;
        chk("tot_clear_wins", tot_count, 64'd0);
        tick;
`endif

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
